// File: rtl/core_lsu_pkg.sv
// core_lsu_pkg: shared types and constants for the load/store sequencer.
// Optional feature macro: CORE_LSU_STDIO_EN adds the stdio FSM states.

package core_lsu_pkg;

    // Default field widths. The request struct is sized from these, so the
    // core_lsu_ctrl parameters must keep the same values.
    localparam int LSU_ADDR_W = 8;
    localparam int LSU_DATA_W = 16;
    localparam int LSU_REG_W  = 4;

    // Address reserved for the console when the stdio feature is built in.
    localparam logic [7:0] STDIO_ADDR = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WB,
        ST_DONE
`ifdef CORE_LSU_STDIO_EN
        ,
        ST_STDIN,
        ST_STDOUT
`endif
    } lsu_state_e;

    // One accepted load/store, captured when the request is accepted.
    typedef struct packed {
        logic                  wen;
        logic [LSU_REG_W-1:0]  rd;
        logic [LSU_ADDR_W-1:0] addr;
        logic [LSU_DATA_W-1:0] wdata;
    } lsu_req_t;

endpackage

// File: rtl/core_lsu_ctrl.sv
// core_lsu_ctrl: sequences the shared data-memory port for one load/store at
// a time, resolves direct/indirect addressing, writes load data back to the
// register file and pulses done_o on completion.
// Optional feature macro: CORE_LSU_STDIO_EN routes address 8'hFF to a
// stdin/stdout handshake instead of data memory.

module core_lsu_ctrl
    import core_lsu_pkg::*;
#(
    parameter int ADDR_W = LSU_ADDR_W,
    parameter int DATA_W = LSU_DATA_W,
    parameter int REG_W  = LSU_REG_W
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              req_en_i,
    input  logic              req_wen_i,
    input  logic              req_kind_i,
    input  logic [REG_W-1:0]  req_rd_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_rt_val_i,
    input  logic [DATA_W-1:0] req_rd_val_i,

    output logic              busy_o,
    output logic              done_o,

    output logic              mem_req_o,
    output logic              mem_wen_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,

`ifdef CORE_LSU_STDIO_EN
    input  logic              stdin_valid_i,
    input  logic [DATA_W-1:0] stdin_data_i,
    output logic              stdin_ready_o,
    output logic              stdout_valid_o,
    output logic [DATA_W-1:0] stdout_data_o,
    input  logic              stdout_ready_i,
`endif

    output logic              arf_wen_o,
    output logic [REG_W-1:0]  arf_waddr_o,
    output logic [DATA_W-1:0] arf_wdata_o
);

    lsu_state_e        state_q;
    lsu_state_e        state_d;
    lsu_req_t          req_q;
    logic [DATA_W-1:0] rdata_q;
    logic [ADDR_W-1:0] eff_addr;
    logic              accept;

    // Only the low address bits of R[t] form the indirect address.
    logic unused_rt_hi;
    assign unused_rt_hi = ^req_rt_val_i[DATA_W-1:ADDR_W];

    // A request is taken only from IDLE; a pulse while busy is dropped.
    assign accept   = req_en_i && (state_q == ST_IDLE);
    assign eff_addr = req_kind_i ? req_addr_i : req_rt_val_i[ADDR_W-1:0];

    // State register with synchronous reset.
    // NOTE: every always_ff uses non-blocking (<=) so all registers update
    // from the same pre-edge values; blocking here creates order-dependent races.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request register: captures the resolved operation on accept.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_q <= '0;
        end else if (accept) begin
            req_q.wen   <= req_wen_i;
            req_q.rd    <= req_rd_i;
            req_q.addr  <= eff_addr;
            req_q.wdata <= req_rd_val_i;
        end
    end

    // Load data capture from memory (or stdin) for the write-back cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (state_q == ST_REQ && mem_ack_i && !req_q.wen) begin
            rdata_q <= mem_rdata_i;
`ifdef CORE_LSU_STDIO_EN
        end else if (state_q == ST_STDIN && stdin_valid_i) begin
            rdata_q <= stdin_data_i;
`endif
        end
    end

    // Next-state and output decode from registered state and fields only.
    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        busy_o      = (state_q != ST_IDLE);
        done_o      = 1'b0;
        mem_req_o   = 1'b0;
        mem_wen_o   = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        arf_wen_o   = 1'b0;
        arf_waddr_o = '0;
        arf_wdata_o = '0;
`ifdef CORE_LSU_STDIO_EN
        stdin_ready_o  = 1'b0;
        stdout_valid_o = 1'b0;
        stdout_data_o  = '0;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (req_en_i) begin
`ifdef CORE_LSU_STDIO_EN
                    if (eff_addr == STDIO_ADDR[ADDR_W-1:0]) begin
                        state_d = req_wen_i ? ST_STDOUT : ST_STDIN;
                    end else begin
                        state_d = ST_REQ;
                    end
`else
                    state_d = ST_REQ;
`endif
                end
            end

            ST_REQ: begin
                // Address, write enable and data stay stable until the ack.
                mem_req_o   = 1'b1;
                mem_wen_o   = req_q.wen;
                mem_addr_o  = req_q.addr;
                mem_wdata_o = req_q.wdata;
                if (mem_ack_i) begin
                    state_d = req_q.wen ? ST_DONE : ST_WB;
                end
            end

            ST_WB: begin
                // R0 is hard-wired zero: skip the write but still complete.
                arf_wen_o   = (req_q.rd != '0);
                arf_waddr_o = req_q.rd;
                arf_wdata_o = rdata_q;
                done_o      = 1'b1;
                state_d     = ST_IDLE;
            end

            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end

`ifdef CORE_LSU_STDIO_EN
            ST_STDIN: begin
                stdin_ready_o = 1'b1;
                if (stdin_valid_i) begin
                    state_d = ST_WB;
                end
            end

            ST_STDOUT: begin
                stdout_valid_o = 1'b1;
                stdout_data_o  = req_q.wdata;
                if (stdout_ready_i) begin
                    state_d = ST_DONE;
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A request pulse while an operation is in flight is a decoder bug.
    assert property (@(posedge clk_i) disable iff (rst_i) !(req_en_i && busy_o))
        else $warning("core_lsu_ctrl: req_en_i while busy_o, request ignored");

endmodule

// File: tb/tb_core_lsu_ctrl.sv
// tb_core_lsu_ctrl: directed bench for core_lsu_ctrl with a scoreboard of
// expected operations and a small latency-programmable memory model.
// Optional feature macro: CORE_LSU_STDIO_EN enables the stdio steps.

module tb_core_lsu_ctrl;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int REG_W  = 4;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              req_en_i;
    logic              req_wen_i;
    logic              req_kind_i;
    logic [REG_W-1:0]  req_rd_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [DATA_W-1:0] req_rt_val_i;
    logic [DATA_W-1:0] req_rd_val_i;
    logic              busy_o;
    logic              done_o;
    logic              mem_req_o;
    logic              mem_wen_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              arf_wen_o;
    logic [REG_W-1:0]  arf_waddr_o;
    logic [DATA_W-1:0] arf_wdata_o;
`ifdef CORE_LSU_STDIO_EN
    logic              stdin_valid_i;
    logic [DATA_W-1:0] stdin_data_i;
    logic              stdin_ready_o;
    logic              stdout_valid_o;
    logic [DATA_W-1:0] stdout_data_o;
    logic              stdout_ready_i;
`endif

    core_lsu_ctrl #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .REG_W (REG_W)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_en_i     (req_en_i),
        .req_wen_i    (req_wen_i),
        .req_kind_i   (req_kind_i),
        .req_rd_i     (req_rd_i),
        .req_addr_i   (req_addr_i),
        .req_rt_val_i (req_rt_val_i),
        .req_rd_val_i (req_rd_val_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .mem_req_o    (mem_req_o),
        .mem_wen_o    (mem_wen_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i),
`ifdef CORE_LSU_STDIO_EN
        .stdin_valid_i (stdin_valid_i),
        .stdin_data_i  (stdin_data_i),
        .stdin_ready_o (stdin_ready_o),
        .stdout_valid_o(stdout_valid_o),
        .stdout_data_o (stdout_data_o),
        .stdout_ready_i(stdout_ready_i),
`endif
        .arf_wen_o    (arf_wen_o),
        .arf_waddr_o  (arf_waddr_o),
        .arf_wdata_o  (arf_wdata_o)
    );

    always #5 clk_i = ~clk_i;

    // Expected operation: pushed on issue, popped when done_o is seen.
    typedef struct {
        bit          wen;
        bit          stdio;
        logic [3:0]  rd;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          waits;
        int          lat;
        int          t_acc;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_checks   = 0;
    int   n_errors   = 0;
    int   cyc        = 0;
    int   req_cycles = 0;
    bit   mon_en     = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Monitor, memory model and scoreboard, sampled on the falling edge.
    always @(negedge clk_i) begin
        if (mon_en) begin
            if (mem_req_o) begin
                if (exp_q.size() == 0) begin
                    check("mem_req_unexpected", mem_req_o, 1'b0);
                end else begin
                    req_cycles++;
                    check("stdio_leak", mem_req_o, !exp_q[0].stdio);
                    check("mem_addr", mem_addr_o, exp_q[0].addr);
                    check("mem_wen", mem_wen_o, exp_q[0].wen);
                    check("mem_wdata", mem_wdata_o, exp_q[0].wdata);
                    if (req_cycles > exp_q[0].waits) begin
                        mem_ack_i   = 1'b1;
                        mem_rdata_i = exp_q[0].rdata;
                    end else begin
                        mem_ack_i   = 1'b0;
                        mem_rdata_i = 16'hDEAD;
                    end
                end
            end else begin
                mem_ack_i   = 1'b0;
                mem_rdata_i = 16'hDEAD;
                check("mem_wen_idle", mem_wen_o, 1'b0);
                check("mem_wdata_idle", mem_wdata_o, '0);
            end

            if (done_o) begin
                if (exp_q.size() == 0) begin
                    check("done_unexpected", done_o, 1'b0);
                end else begin
                    cur = exp_q.pop_front();
                    if (!cur.wen) begin
                        check("arf_wen", arf_wen_o, (cur.rd != 4'd0));
                        check("arf_waddr", arf_waddr_o, cur.rd);
                        check("arf_wdata", arf_wdata_o, cur.rdata);
                    end else begin
                        check("arf_wen_store", arf_wen_o, 1'b0);
                    end
                    if (!cur.stdio) begin
                        check("mem_req_cycles", req_cycles, cur.waits + 1);
                        check("latency", cyc - cur.t_acc, cur.lat);
                    end
                    req_cycles = 0;
                end
            end else begin
                check("arf_wen_idle", arf_wen_o, 1'b0);
            end
        end
    end

    // Drive one request for a single cycle and record what it should do.
    task automatic issue(input bit wen, input bit kind, input logic [3:0] rd,
                         input logic [7:0] imm, input logic [15:0] rt,
                         input logic [15:0] rdv, input int waits,
                         input logic [15:0] rdata);
        exp_t e;
        @(posedge clk_i); #1;
        req_en_i     = 1'b1;
        req_wen_i    = wen;
        req_kind_i   = kind;
        req_rd_i     = rd;
        req_addr_i   = imm;
        req_rt_val_i = rt;
        req_rd_val_i = rdv;
        e.wen   = wen;
        e.rd    = rd;
        e.addr  = kind ? imm : rt[7:0];
        e.stdio = 1'b0;
`ifdef CORE_LSU_STDIO_EN
        e.stdio = (e.addr == 8'hFF);
`endif
        e.wdata = rdv;
        e.rdata = rdata;
        e.waits = waits;
        e.lat   = 2 + waits;
        e.t_acc = cyc;
        exp_q.push_back(e);
        @(posedge clk_i); #1;
        req_en_i = 1'b0;
    endtask

    // Bounded wait for done_o; returns inside the done cycle.
    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk_i); #2;
            seen = done_o;
        end
        check({tag, "_done_seen"}, seen, 1'b1);
    endtask

    initial begin
        rst_i        = 1'b1;
        req_en_i     = 1'b1;
        req_wen_i    = 1'b0;
        req_kind_i   = 1'b1;
        req_rd_i     = 4'd1;
        req_addr_i   = 8'h10;
        req_rt_val_i = '0;
        req_rd_val_i = '0;
        mem_ack_i    = 1'b0;
        mem_rdata_i  = '0;
`ifdef CORE_LSU_STDIO_EN
        stdin_valid_i  = 1'b0;
        stdin_data_i   = '0;
        stdout_ready_i = 1'b0;
`endif

        // Reset dominates a request pulse; all outputs are zero.
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_mem_req", mem_req_o, 1'b0);
        check("rst_mem_addr", mem_addr_o, '0);
        check("rst_arf_wen", arf_wen_o, 1'b0);
        check("rst_arf_waddr", arf_waddr_o, '0);
        check("rst_arf_wdata", arf_wdata_o, '0);
        req_en_i = 1'b0;
        rst_i    = 1'b0;
        mon_en   = 1'b1;

        // Direct load, two wait states.
        issue(1'b0, 1'b1, 4'd3, 8'h12, 16'h5678, 16'h1111, 2, 16'hBEEF);
        wait_done("direct_load");

        // Indirect store, zero-wait memory.
        issue(1'b1, 1'b0, 4'd9, 8'h99, 16'h1234, 16'hCAFE, 0, 16'h0000);
        wait_done("indirect_store");

        // Load to R0: no write-back, done still fires, busy falls next cycle.
        issue(1'b0, 1'b1, 4'd0, 8'h40, 16'h0000, 16'h0000, 0, 16'hFFFF);
        wait_done("load_r0");
        @(posedge clk_i); #2;
        check("busy_after_r0", busy_o, 1'b0);

        // Reset while waiting on an ack that never comes.
        issue(1'b0, 1'b1, 4'd6, 8'h33, 16'h0000, 16'h0000, 100, 16'h7777);
        @(posedge clk_i); #1;
        check("midop_busy", busy_o, 1'b1);
        check("midop_mem_req", mem_req_o, 1'b1);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        exp_q.delete();
        req_cycles = 0;
        check("midop_rst_mem_req", mem_req_o, 1'b0);
        check("midop_rst_busy", busy_o, 1'b0);
        check("midop_rst_done", done_o, 1'b0);
        repeat (3) @(posedge clk_i);
        #1;
        check("midop_idle_busy", busy_o, 1'b0);

        // Fresh request after the reset.
        issue(1'b0, 1'b1, 4'd7, 8'h56, 16'h0000, 16'h0000, 1, 16'h0A5A);
        wait_done("after_reset");

        // Back-to-back: second request in the cycle right after done_o.
        issue(1'b1, 1'b1, 4'd2, 8'h20, 16'h0000, 16'h1357, 0, 16'h0000);
        wait_done("b2b_first");
        issue(1'b0, 1'b1, 4'd5, 8'h21, 16'h0000, 16'h0000, 3, 16'h2468);
        // Stray request while busy must not disturb the load in flight.
        req_en_i     = 1'b1;
        req_wen_i    = 1'b1;
        req_kind_i   = 1'b1;
        req_rd_i     = 4'd4;
        req_addr_i   = 8'h77;
        req_rd_val_i = 16'hFFFF;
        check("busy_ignored", busy_o, 1'b1);
        @(posedge clk_i); #1;
        req_en_i = 1'b0;
        wait_done("b2b_second");

`ifdef CORE_LSU_STDIO_EN
        // Load from stdin: data arrives after five cycles of ready.
        issue(1'b0, 1'b1, 4'd4, 8'hFF, 16'h0000, 16'h0000, 0, 16'h0042);
        repeat (5) begin
            check("stdin_ready", stdin_ready_o, 1'b1);
            @(posedge clk_i); #1;
        end
        stdin_valid_i = 1'b1;
        stdin_data_i  = 16'h0042;
        wait_done("stdin_load");
        stdin_valid_i = 1'b0;

        // Store to stdout: valid and data held until ready.
        issue(1'b1, 1'b0, 4'd8, 8'h00, 16'h00FF, 16'hABCD, 0, 16'h0000);
        repeat (3) begin
            check("stdout_valid", stdout_valid_o, 1'b1);
            check("stdout_data", stdout_data_o, 16'hABCD);
            @(posedge clk_i); #1;
        end
        stdout_ready_i = 1'b1;
        wait_done("stdout_store");
        stdout_ready_i = 1'b0;
`else
        // Without stdio, 8'hFF is an ordinary memory address.
        issue(1'b1, 1'b1, 4'd1, 8'hFF, 16'h0000, 16'h00FF, 0, 16'h0000);
        wait_done("ff_store");
        issue(1'b0, 1'b0, 4'd8, 8'h00, 16'hABFF, 16'h0000, 0, 16'h5A5A);
        wait_done("ff_load");
`endif

        repeat (2) @(posedge clk_i);
        #1;
        check("end_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/core_lsu_ctrl.md
Name: core_lsu_ctrl

Overview:
- Sequences the single shared data-memory port on behalf of the decoder cascade.
- Accepts one load/store request per issue, resolves the effective address (direct or indirect), and runs the memory handshake.
- Writes load data back to the register file, then signals completion so the decoder cascade can release its stall and dirty state.
- Sits between the decoder preempt path, the register file write port and data memory.

Parameters:
- ADDR_W, 8, memory address width (TOY 256-word space)
- DATA_W, 16, data word width
- REG_W, 4, register index width

Ports:
- clk_i  input  1  core clock
- rst_i  input  1  synchronous active-high reset
- req_en_i  input  1  LSU request from decoder preempt path, single-cycle pulse
- req_wen_i  input  1  1 = store, 0 = load
- req_kind_i  input  1  1 = direct address (instr[7:0]), 0 = indirect (R[t][7:0])
- req_rd_i  input  REG_W  destination register (load) or source register (store)
- req_addr_i  input  ADDR_W  instruction immediate address
- req_rt_val_i  input  DATA_W  R[t] value, used for indirect address
- req_rd_val_i  input  DATA_W  R[d] value, used as store data
- busy_o  output  1  operation in flight
- done_o  output  1  one-cycle completion pulse
- mem_req_o  output  1  memory request
- mem_wen_o  output  1  memory write enable
- mem_addr_o  output  ADDR_W  memory address
- mem_wdata_o  output  DATA_W  memory write data
- mem_ack_i  input  1  memory acknowledge
- mem_rdata_i  input  DATA_W  memory read data, valid with mem_ack_i
- arf_wen_o  output  1  register file write enable
- arf_waddr_o  output  REG_W  register file write index
- arf_wdata_o  output  DATA_W  register file write data

Behaviour:
- Clock and reset: clk_i is the only clock; rst_i is synchronous and active-high.
- Reset: state returns to IDLE and every output is driven to 0. A reset during REQ drops mem_req_o on the next edge without waiting for mem_ack_i; no write-back and no done_o are produced.
- States: IDLE, REQ, WB, DONE; ST_STDIN and ST_STDOUT exist only with the optional feature.
- IDLE:
  - On req_en_i, register wen, rd, addr and wdata. addr = req_kind_i ? req_addr_i : req_rt_val_i[7:0]; wdata = req_rd_val_i.
  - Next state is REQ.
- REQ:
  - mem_req_o = 1, with mem_wen_o, mem_addr_o and mem_wdata_o held stable until mem_ack_i.
  - On ack: a load captures mem_rdata_i and goes to WB; a store goes to DONE.
  - There is no timeout; mem_req_o is held indefinitely.
- WB (one cycle):
  - arf_wen_o = (rd != 0), arf_waddr_o = rd, arf_wdata_o = captured data, done_o = 1.
  - Returns to IDLE.
- DONE (one cycle): done_o = 1, then returns to IDLE.
- busy_o = (state != IDLE). The accept cycle itself is covered by the decoder's own stall.
- req_en_i while busy_o = 1 is a protocol error: it is ignored and flagged by an assertion.
- Latency with zero-wait memory (accept at cycle T):
  - Ack at T+1.
  - Load write-back plus done_o at T+2.
  - Store done_o at T+2.
  - Each memory wait cycle adds one cycle.
- Outputs are decoded from registered state and registered fields; mem_ack_i has no combinational path to mem_req_o.
- mem_wen_o and mem_wdata_o are 0 whenever mem_req_o = 0.
- Write-back to R0 is suppressed, but done_o still fires.

Optional Feature:
- Macro: CORE_LSU_STDIO_EN.
- When defined:
  - Address 8'hFF is routed to stdio and never reaches mem_*.
  - Additional ports: stdin_valid_i, stdin_data_i[DATA_W], stdin_ready_o, stdout_valid_o, stdout_data_o[DATA_W], stdout_ready_i.
  - Load from FF: ST_STDIN with stdin_ready_o = 1 until stdin_valid_i, capture stdin_data_i, then WB.
  - Store to FF: ST_STDOUT with stdout_valid_o = 1 and data held until stdout_ready_i, then DONE.
  - The stdio outputs reset to 0.
- When undefined: the stdio ports do not exist, and FF is an ordinary memory address.

Decomposition:
- Package core_lsu_pkg holds:
  - the state enum
  - localparam STDIO_ADDR = 8'hFF
  - a packed request struct {wen, rd, addr, wdata}
- No sub-module; the block is a single FSM with a request register.

Test Plan:
- Direct load: req_kind=1, addr=0x12, rd=3, mem returns 0xBEEF after 2 waits -> mem_addr_o = 0x12 held for 3 cycles; arf_wen_o with waddr 3 and data 0xBEEF together with done_o, 4 cycles after accept.
- Indirect store: req_kind=0, rt_val=0x1234, rd_val=0xCAFE, zero-wait ack -> mem_addr_o = 0x34, mem_wen_o = 1, mem_wdata_o = 0xCAFE; done_o at T+2; arf_wen_o never asserted.
- Load to R0: rd=0, rdata 0xFFFF -> arf_wen_o stays 0; done_o still pulses; busy_o falls on the next cycle.
- Reset mid-op: rst_i asserted while in REQ, no ack -> next cycle mem_req_o = 0, busy_o = 0, no done_o; a fresh request is then accepted normally.
- Back-to-back: second req_en_i on the cycle after done_o -> accepted. req_en_i during busy_o -> ignored; the assertion fires and the original operation completes unchanged.
- STDIO (macro on): load from FF with stdin_valid_i after 5 cycles and data 0x0042 -> no mem_req_o; write-back of 0x0042. Store to FF -> stdout_valid_o held until stdout_ready_i, then done_o.
